// File: rtl/gf2m_trinomial_reduce_pkg.sv
// Shared types and constants for the GF(2^m) trinomial reducer.
// The default field is B-409: f(x) = x^409 + x^87 + 1.
package gf2m_trinomial_reduce_pkg;
  localparam int B409_M = 409;
  localparam int B409_K = 87;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FOLD1 = 2'd1,
    FOLD2 = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/gf2m_trinomial_reduce_if.sv
// Stream interface between the multiplier, the reducer and the result consumer.
interface gf2m_trinomial_reduce_if
  import gf2m_trinomial_reduce_pkg::*;
#(
  parameter int M = B409_M
);
  // Both sides use valid/ready: a transfer happens on a rising edge where valid
  // and ready are both 1; once raised, valid and its data hold until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [2*M-1:0]   in_c;
  logic             out_valid;
  logic             out_ready;
  logic [M-1:0]     out_r;

  modport master (
    output in_valid, in_c, out_ready,
    input  in_ready, out_valid, out_r
  );

  modport slave (
    input  in_valid, in_c, out_ready,
    output in_ready, out_valid, out_r
  );
endinterface

// File: rtl/gf2m_trinomial_fold.sv
// One reduction step: fold the upper half h back using x^M == x^K + 1.
// The shift is done at full 2M width so h*x^K keeps its overflow for the next fold.
module gf2m_trinomial_fold
  import gf2m_trinomial_reduce_pkg::*;
#(
  parameter int M = B409_M,
  parameter int K = B409_K
) (
  input  logic [2*M-1:0] w_in,
  output logic [2*M-1:0] w_out
);
  logic [2*M-1:0] h_ext;
  logic [2*M-1:0] l_ext;

  assign h_ext = {{M{1'b0}}, w_in[2*M-1:M]};
  assign l_ext = {{M{1'b0}}, w_in[M-1:0]};
  assign w_out = l_ext ^ h_ext ^ (h_ext << K);
endmodule

// File: rtl/gf2m_trinomial_reduce.sv
// Reduces a 2M-bit GF(2) product modulo x^M + x^K + 1 with two sequential folds.
// A new operand may be accepted in the same edge that hands off the previous result.
module gf2m_trinomial_reduce
  import gf2m_trinomial_reduce_pkg::*;
#(
  parameter int M = B409_M,
  parameter int K = B409_K
) (
  input  logic                     clk,
  input  logic                     rst,
  gf2m_trinomial_reduce_if.slave   bus,
  output state_e                   dbg_state
);
  state_e         state_q;
  state_e         state_d;
  logic [2*M-1:0] w_q;
  logic [2*M-1:0] w_d;
  logic [2*M-1:0] w_fold;

  gf2m_trinomial_fold #(.M(M), .K(K)) u_fold (
    .w_in  (w_q),
    .w_out (w_fold)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_d     = bus.in_c;
          state_d = FOLD1;
        end
      end
      FOLD1: begin
        w_d     = w_fold;
        state_d = FOLD2;
      end
      FOLD2: begin
        // Second fold leaves the upper half zero because 2K <= M.
        w_d     = w_fold;
        state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            w_d     = bus.in_c;
            state_d = FOLD1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_r = w_q[M-1:0];
  assign dbg_state = state_q;
endmodule

// File: tb/tb_gf2m_trinomial_reduce.sv
// Directed and random-product bench for the B-409 trinomial reducer.
module tb_gf2m_trinomial_reduce;
  import gf2m_trinomial_reduce_pkg::*;

  localparam int M = 409;
  localparam int K = 87;
  localparam int W = 2 * M;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     checks;
  int     errors;
  logic [M-1:0] exp_q[$];

  gf2m_trinomial_reduce_if #(.M(M)) bus ();

  gf2m_trinomial_reduce #(.M(M), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] bit_w(input int i);
    logic [W-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [M-1:0] bit_m(input int i);
    logic [M-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [M-1:0] rand_m();
    logic [415:0] t;
    for (int i = 0; i < 13; i++) t[i*32 +: 32] = $urandom();
    return t[M-1:0];
  endfunction

  // Multiplier model: carry-less a*b
  function automatic logic [W-1:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++)
      if (b[i]) r = r ^ ({{M{1'b0}}, a} << i);
    return r;
  endfunction

  // Reference: long division, clearing one top bit at a time
  function automatic logic [M-1:0] mod_f(input logic [W-1:0] c);
    logic [W-1:0] t;
    t = c;
    for (int i = W - 1; i >= M; i--) begin
      if (t[i]) begin
        t[i]         = 1'b0;
        t[i - M + K] = ~t[i - M + K];
        t[i - M]     = ~t[i - M];
      end
    end
    return t[M-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_c      = bit_w(817);
    bus.out_ready = 1'b1;
    #2;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.out_r !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: out_r=%h state=%0d, want 0 IDLE", bus.out_r, dbg_state);
    end
    @(posedge clk); #1;
    checks++;
    if (dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_no_accept: state=%0d, want IDLE", dbg_state);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] vin [6];
    logic [M-1:0] vexp[6];
    vin[0] = bit_w(817); vexp[0] = bit_m(408) | bit_m(173) | bit_m(86);
    vin[1] = bit_w(409); vexp[1] = bit_m(87) | bit_m(0);
    vin[2] = bit_w(0);   vexp[2] = bit_m(0);
    vin[3] = bit_w(731); vexp[3] = bit_m(322) | bit_m(87) | bit_m(0);
    vin[4] = bit_w(408); vexp[4] = bit_m(408);
    vin[5] = {{M{1'b0}}, 409'h1_2345_6789_abcd_ef01_0000_0000_dead_beef};
    vexp[5] = 409'h1_2345_6789_abcd_ef01_0000_0000_dead_beef;
    bus.out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      bus.in_valid = 1'b1;
      bus.in_c     = vin[v];
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_c     = ~vin[v];
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || dbg_state !== FOLD1) begin
        errors++;
        $display("FAIL dir%0d_fold1: in_ready=%b out_valid=%b state=%0d, want 0 0 FOLD1",
                 v, bus.in_ready, bus.out_valid, dbg_state);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_fold2: in_ready=%b out_valid=%b, want 0 0", v, bus.in_ready, bus.out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_r !== vexp[v]) begin
        errors++;
        $display("FAIL dir%0d_result: out_valid=%b out_r=%h, want 1 %h", v, bus.out_valid, bus.out_r, vexp[v]);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || dbg_state !== IDLE) begin
        errors++;
        $display("FAIL dir%0d_consume: out_valid=%b state=%0d, want 0 IDLE", v, bus.out_valid, dbg_state);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [M-1:0] want;
    want = bit_m(87) | bit_m(0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_c      = bit_w(409);
    @(posedge clk); #1;
    bus.in_c = bit_w(817);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_r !== want || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d: out_valid=%b in_ready=%b out_r=%h, want 1 0 %h",
                 i, bus.out_valid, bus.in_ready, bus.out_r, want);
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b, want 1 1", bus.in_ready, bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL stall_consume: out_valid=%b state=%0d, want 0 IDLE", bus.out_valid, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] cur_c;
    logic [M-1:0] cur_exp;
    logic [M-1:0] want;
    logic         acc;
    int sent, got, cyc, last_acc;
    sent = 0; got = 0; cyc = 0; last_acc = -1;
    cur_c   = clmul(rand_m(), rand_m());
    cur_exp = mod_f(cur_c);
    bus.in_c      = cur_c;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    while (got < 100 && cyc < 1000) begin
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: out_valid with nothing outstanding, out_r=%h", bus.out_r);
        end else begin
          want = exp_q.pop_front();
          if (bus.out_r !== want) begin
            errors++;
            $display("FAIL b2b_%0d: out_r=%h, want %h", got, bus.out_r, want);
          end
        end
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        exp_q.push_back(cur_exp);
        sent++;
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 3) begin
            errors++;
            $display("FAIL b2b_rate: accept spacing=%0d, want 3", cyc - last_acc);
          end
        end
        last_acc = cyc;
        if (sent < 100) begin
          cur_c   = clmul(rand_m(), rand_m());
          cur_exp = mod_f(cur_c);
          bus.in_c = cur_c;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (got != 100) begin
      errors++;
      $display("FAIL b2b_timeout: results=%0d, want 100", got);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    logic [M-1:0] want;
    want = bit_m(408) | bit_m(173) | bit_m(86);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_c      = '1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (dbg_state !== FOLD1) begin
      errors++;
      $display("FAIL mid_reach_fold1: state=%0d, want FOLD1", dbg_state);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.out_r !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL mid_async: out_r=%h out_valid=%b in_ready=%b state=%0d, want 0 0 1 IDLE",
               bus.out_r, bus.out_valid, bus.in_ready, dbg_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_ghost%0d: out_valid=%b, want 0", i, bus.out_valid);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_c     = bit_w(817);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_r !== want) begin
      errors++;
      $display("FAIL mid_next: out_valid=%b out_r=%h, want 1 %h", bus.out_valid, bus.out_r, want);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
